// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: samples sdi on sample_pulse strobes while cs is high and assembles WIDTH-bit words.
// Latency: a word appears on data_out/data_valid one clk after the edge that sampled its final bit.
// Backpressure: data_out is held until data_ack; a word that completes while one is still pending is dropped and sets overrun.
//
// Ports: clk, reset (async active-high), cs (frame enable), sample_pulse (strobe),
//        sdi (serial data), data_ack (consumer took data_out) ->
//        data_out, data_valid, overrun (sticky), frame_err (pulse), parity_err (pulse), busy.
// Optional feature: define PARITY_CHECK_EN to expect an even-parity bit after each word.
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sample_pulse,
    input  logic             sdi,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  sr_nxt;
    logic              word_done;   // full word sitting in sr, apply accept rules this cycle
    logic              last_bit;
    logic              shift_in;
    logic              in_parity;

    assign last_bit = (count == CW'(WIDTH - 1));
    assign shift_in = cs && sample_pulse && (state == SHIFT);
    assign sr_nxt   = MSB_FIRST ? {sr[WIDTH-2:0], sdi} : {sdi, sr[WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
    assign in_parity = (state == PARITY);
`else
    assign in_parity = 1'b0;
`endif

    assign busy = (state != IDLE) && ((count != '0) || in_parity);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cs) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!cs) begin
                    state_nxt = IDLE;
`ifdef PARITY_CHECK_EN
                end else if (sample_pulse && last_bit) begin
                    state_nxt = PARITY;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (!cs)               state_nxt = IDLE;
                else if (sample_pulse) state_nxt = SHIFT;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            sr         <= '0;
            word_done  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            word_done  <= 1'b0;

            // cs has priority over a coincident strobe; a partial word is abandoned.
            if ((state != IDLE) && !cs) begin
                count     <= '0;
                frame_err <= (count != '0) || in_parity;
            end else if (shift_in) begin
                sr <= sr_nxt;
                if (last_bit) begin
                    count <= '0;
`ifndef PARITY_CHECK_EN
                    word_done <= 1'b1;
`endif
                end else begin
                    count <= count + 1'b1;
                end
`ifdef PARITY_CHECK_EN
            end else if (in_parity && cs && sample_pulse) begin
                // Even parity over data plus parity bit must be zero.
                if (^{sr, sdi}) parity_err <= 1'b1;
                else            word_done  <= 1'b1;
`endif
            end

            // sr may shift again this cycle for a back-to-back word; the load
            // takes the value before that shift.
            if (word_done) begin
                if (!data_valid || data_ack) begin
                    data_out   <= sr;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver (WIDTH=8, MSB first).
// Stimulus pushes expected events into a scoreboard; a negedge monitor pops and compares.
// Direct checks cover reset values, latency, overrun, busy and pulse widths.
module tb_serial_word_receiver;

    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       sample_pulse;
    logic       sdi;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    int         exp_kind[$];
    logic [7:0] exp_val[$];

    serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .sample_pulse (sample_pulse),
        .sdi          (sdi),
        .data_ack     (data_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] v);
        exp_kind.push_back(k);
        exp_val.push_back(v);
    endtask

    task automatic send_bit(input logic b);
        sdi          = b;
        sample_pulse = 1'b1;
        tick();
        sample_pulse = 1'b0;
        tick();
    endtask

    // Sends 8 data bits MSB first, then (parity build only) parity bit p.
    // With chk_lat set, checks data_valid is still low right after the final
    // sampling edge and high one clk later.
    task automatic send_raw(input logic [7:0] w, input logic p, input logic chk_lat);
        logic [7:0] v;
        v = w;
        for (int i = 7; i >= 0; i--) begin
`ifdef PARITY_CHECK_EN
            send_bit(v[i]);
`else
            if (i != 0 || !chk_lat) begin
                send_bit(v[i]);
            end else begin
                sdi = v[i]; sample_pulse = 1'b1; tick(); sample_pulse = 1'b0;
                chk("latency_not_yet", {31'd0, data_valid}, 32'd0);
                tick();
                chk("latency_valid", {31'd0, data_valid}, 32'd1);
            end
`endif
        end
`ifdef PARITY_CHECK_EN
        if (!chk_lat) begin
            send_bit(p);
        end else begin
            sdi = p; sample_pulse = 1'b1; tick(); sample_pulse = 1'b0;
            chk("latency_not_yet", {31'd0, data_valid}, 32'd0);
            tick();
            chk("latency_valid", {31'd0, data_valid}, 32'd1);
        end
`else
        if (p === 1'bx) $display("parity unused");
`endif
    endtask

    task automatic send_word(input logic [7:0] w, input logic chk_lat);
        send_raw(w, ^w, chk_lat);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    task automatic mon_pop(input int kind, input logic [7:0] val);
        int         k;
        logic [7:0] v;
        if (exp_kind.size() == 0) begin
            n_total++;
            $display("FAIL mon_unexpected: got event kind %0d value 0x%0h, expected none (t=%0t)", kind, val, $time);
        end else begin
            k = exp_kind.pop_front();
            v = exp_val.pop_front();
            chk("mon_kind", kind, k);
            if (k == K_WORD && kind == K_WORD) chk("mon_data", {24'd0, val}, {24'd0, v});
        end
    endtask

    // Monitor: new word = rising data_valid; error pulses popped as they appear.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (data_valid && !prev_v) mon_pop(K_WORD, data_out);
                if (frame_err)             mon_pop(K_FERR, 8'h00);
                if (parity_err)            mon_pop(K_PERR, 8'h00);
                prev_v = data_valid;
            end
        end
    end

    initial begin
        reset = 1'b1; cs = 1'b0; sample_pulse = 1'b0; sdi = 1'b0; data_ack = 1'b0;
        tick(); tick();
        chk("rst_data_out",   {24'd0, data_out}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_overrun",    {31'd0, overrun}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rel_frame_err", {31'd0, frame_err}, 32'd0);

        // 1: single word with latency and ack
        cs = 1'b1; tick();
        push(K_WORD, 8'hA5);
        send_word(8'hA5, 1'b1);
        chk("t1_data", {24'd0, data_out}, 32'hA5);
        ack();
        chk("t1_ack_clears", {31'd0, data_valid}, 32'd0);

        // 2: two words in the same frame, idle between words
        push(K_WORD, 8'h3C);
        send_word(8'h3C, 1'b0);
        chk("t2_busy_between", {31'd0, busy}, 32'd0);
        ack();
        push(K_WORD, 8'hC3);
        send_word(8'hC3, 1'b0);
        chk("t2_no_overrun", {31'd0, overrun}, 32'd0);
        ack();

        // 3: overrun when the second word arrives before an ack
        push(K_WORD, 8'h11);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("t3_data_held", {24'd0, data_out}, 32'h11);
        chk("t3_overrun",   {31'd0, overrun}, 32'd1);
        ack();
        chk("t3_valid_clr",   {31'd0, data_valid}, 32'd0);
        chk("t3_overrun_clr", {31'd0, overrun}, 32'd0);

        // 4: cs drops after 3 bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        push(K_FERR, 8'h00);
        cs = 1'b0; tick();
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        tick();
        chk("t4_pulse_1clk", {31'd0, frame_err}, 32'd0);
        chk("t4_no_valid",   {31'd0, data_valid}, 32'd0);
        cs = 1'b1; tick();
        push(K_WORD, 8'h5A);
        send_word(8'h5A, 1'b0);

        // 5: async reset mid-word with a word pending
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5_data_out", {24'd0, data_out}, 32'd0);
        chk("t5_valid",    {31'd0, data_valid}, 32'd0);
        chk("t5_busy",     {31'd0, busy}, 32'd0);
        chk("t5_overrun",  {31'd0, overrun}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_no_ferr", {31'd0, frame_err}, 32'd0);
        push(K_WORD, 8'h81);
        send_word(8'h81, 1'b0);
        ack();

`ifdef PARITY_CHECK_EN
        // 6: good and bad parity
        push(K_WORD, 8'hA5);
        send_raw(8'hA5, 1'b0, 1'b0);
        ack();
        push(K_PERR, 8'h00);
        for (int i = 7; i >= 0; i--) send_bit(((8'hA5 >> i) & 8'h01) != 0);
        sdi = 1'b1; sample_pulse = 1'b1; tick(); sample_pulse = 1'b0;
        chk("t6_parity_err", {31'd0, parity_err}, 32'd1);
        tick();
        chk("t6_no_valid", {31'd0, data_valid}, 32'd0);
`endif

        cs = 1'b0;
        tick(); tick(); tick();
        chk("sb_drained", exp_kind.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
